// File: rtl/battery_gauge_if.sv
// Battery gauge bus: event inputs from the system and level outputs to the state indicator.
// low_warn exists only when BATTERY_GAUGE_LOW_WARN_EN is defined.
interface battery_gauge_if;
  logic       charger_in;
  logic       load_pulse;
  logic       refill;
  logic [4:0] battery;
  logic       level_changed;
  logic       full;
  logic       empty;
`ifdef BATTERY_GAUGE_LOW_WARN_EN
  logic       low_warn;
`endif

  // master: event source / level consumer side
  modport master (
    output charger_in, load_pulse, refill,
    input  battery, level_changed, full, empty
`ifdef BATTERY_GAUGE_LOW_WARN_EN
    , input low_warn
`endif
  );

  // slave: the gauge itself
  modport slave (
    input  charger_in, load_pulse, refill,
    output battery, level_changed, full, empty
`ifdef BATTERY_GAUGE_LOW_WARN_EN
    , output low_warn
`endif
  );
endinterface

// File: rtl/battery_gauge.sv
// Battery level gauge: 0..31 level that drains per tick/load and charges with charger attached.
// Optional hysteretic low_warn output enabled by BATTERY_GAUGE_LOW_WARN_EN.
module battery_gauge #(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned DRAIN_TICKS  = 4,
  parameter int unsigned CHARGE_TICKS = 2,
  parameter int unsigned LOAD_COST    = 3,
  parameter int unsigned INIT_LEVEL   = 31
) (
  input  logic            clk,
  input  logic            rst_n,
  battery_gauge_if.slave  gauge
);

  localparam int unsigned PRE_W   = $clog2(TICK_DIV);
  localparam int unsigned SUB_MAX = (DRAIN_TICKS > CHARGE_TICKS) ? DRAIN_TICKS : CHARGE_TICKS;
  localparam int unsigned SUB_W   = $clog2(SUB_MAX + 1);

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
  localparam logic [SUB_W-1:0] DRAIN_LAST  = SUB_W'(DRAIN_TICKS - 1);
  localparam logic [SUB_W-1:0] CHARGE_LAST = SUB_W'(CHARGE_TICKS - 1);
  localparam logic [5:0]       COST        = 6'((LOAD_COST > 31) ? 31 : LOAD_COST);
  localparam logic [4:0]       FULL_LEVEL  = 5'd31;
  localparam logic [4:0]       INIT_VALUE  = 5'(INIT_LEVEL);

  typedef enum logic [1:0] {
    DISCHARGING,
    CHARGING,
    DEPLETED
  } state_t;

  state_t           state, state_nxt;
  logic             sync1, chg_s;
  logic [PRE_W-1:0] prescale;
  logic             tick;
  logic [SUB_W-1:0] sub, sub_nxt;
  logic [4:0]       level, level_nxt;
  logic             changed, full_q, empty_q;

  logic [5:0] lvl6, minus_cost_raw, minus_one_raw, plus_one_raw;
  logic [4:0] minus_cost, minus_one, plus_one;

  // Two-flop synchronizer for the asynchronous charger detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      chg_s <= 1'b0;
    end else begin
      sync1 <= gauge.charger_in;
      chg_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 prescale <= '0;
    else if (prescale == PRE_LAST) prescale <= '0;
    else                        prescale <= prescale + PRE_W'(1);
  end

  assign tick = (prescale == PRE_LAST);

  // 6-bit arithmetic; bit 5 flags borrow (floor at 0) or carry (ceil at 31)
  assign lvl6           = {1'b0, level};
  assign minus_cost_raw = lvl6 - COST;
  assign minus_one_raw  = lvl6 - 6'd1;
  assign plus_one_raw   = lvl6 + 6'd1;
  assign minus_cost     = minus_cost_raw[5] ? 5'd0 : minus_cost_raw[4:0];
  assign minus_one      = minus_one_raw[5]  ? 5'd0 : minus_one_raw[4:0];
  assign plus_one       = plus_one_raw[5]   ? FULL_LEVEL : plus_one_raw[4:0];

  always_comb begin
    level_nxt = level;
    sub_nxt   = sub;
    state_nxt = state;

    // refill > load_pulse > tick; lower-priority events in the same cycle are dropped
    if (gauge.refill) begin
      level_nxt = FULL_LEVEL;
    end else if (gauge.load_pulse) begin
      if (state != DEPLETED) level_nxt = minus_cost;
    end else if (tick) begin
      unique case (state)
        DISCHARGING: begin
          if (sub == DRAIN_LAST) begin
            sub_nxt   = '0;
            level_nxt = minus_one;
          end else begin
            sub_nxt = sub + SUB_W'(1);
          end
        end
        CHARGING: begin
          if (sub == CHARGE_LAST) begin
            sub_nxt   = '0;
            level_nxt = plus_one;
          end else begin
            sub_nxt = sub + SUB_W'(1);
          end
        end
        default: ;
      endcase
    end

    unique case (state)
      DISCHARGING: begin
        if (chg_s)                   state_nxt = CHARGING;
        else if (level_nxt == 5'd0)  state_nxt = DEPLETED;
      end
      CHARGING: begin
        if (!chg_s) state_nxt = DISCHARGING;
      end
      DEPLETED: begin
        if (gauge.refill) state_nxt = DISCHARGING;
        else if (chg_s)   state_nxt = CHARGING;
      end
      default: state_nxt = DISCHARGING;
    endcase

    if (state_nxt != state) sub_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DISCHARGING;
      sub     <= '0;
      level   <= INIT_VALUE;
      changed <= 1'b0;
      full_q  <= (INIT_VALUE == FULL_LEVEL);
      empty_q <= (INIT_VALUE == 5'd0);
    end else begin
      state   <= state_nxt;
      sub     <= sub_nxt;
      level   <= level_nxt;
      changed <= (level_nxt != level);
      full_q  <= (level_nxt == FULL_LEVEL);
      empty_q <= (level_nxt == 5'd0);
    end
  end

  assign gauge.battery       = level;
  assign gauge.level_changed = changed;
  assign gauge.full          = full_q;
  assign gauge.empty         = empty_q;

`ifdef BATTERY_GAUGE_LOW_WARN_EN
  logic low_q;

  // Hysteresis: set at <=5, clear only at >=10, hold in between
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  low_q <= 1'b0;
    else if (level_nxt <= 5'd5)  low_q <= 1'b1;
    else if (level_nxt >= 5'd10) low_q <= 1'b0;
  end

  assign gauge.low_warn = low_q;
`endif

endmodule

// File: tb/tb_battery_gauge.sv
// Directed + randomized bench for battery_gauge against a cycle-level behavioural model.
module tb_battery_gauge;
  localparam int TICK_DIV     = 4;
  localparam int DRAIN_TICKS  = 2;
  localparam int CHARGE_TICKS = 2;
  localparam int LOAD_COST    = 3;
  localparam int INIT_LEVEL   = 31;

  localparam int M_DRAIN  = 0;
  localparam int M_CHARGE = 1;
  localparam int M_EMPTY  = 2;

  logic clk = 1'b0;
  logic rst_n;

  battery_gauge_if bus ();

  battery_gauge #(
    .TICK_DIV    (TICK_DIV),
    .DRAIN_TICKS (DRAIN_TICKS),
    .CHARGE_TICKS(CHARGE_TICKS),
    .LOAD_COST   (LOAD_COST),
    .INIT_LEVEL  (INIT_LEVEL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .gauge(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int strobes;

  // Behavioural model: level, mode, ticks elapsed, base-tick phase, charger pipeline
  int m_lvl, m_mode, m_pre, m_sub, m_s1, m_s2, m_lc, m_lw;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl  = INIT_LEVEL;
    m_mode = M_DRAIN;
    m_pre  = 0;
    m_sub  = 0;
    m_s1   = 0;
    m_s2   = 0;
    m_lc   = 0;
    m_lw   = 0;
  endtask

  task automatic model_edge();
    int  nl, nsub, nmode, lim;
    bit  tick, chg;
    tick  = (m_pre == TICK_DIV - 1);
    chg   = (m_s2 != 0);
    nl    = m_lvl;
    nsub  = m_sub;
    if (bus.refill) begin
      nl = 31;
    end else if (bus.load_pulse) begin
      if (m_mode != M_EMPTY) nl = (m_lvl > LOAD_COST) ? m_lvl - LOAD_COST : 0;
    end else if (tick && m_mode != M_EMPTY) begin
      lim = (m_mode == M_DRAIN) ? DRAIN_TICKS : CHARGE_TICKS;
      if (m_sub + 1 >= lim) begin
        nsub = 0;
        if (m_mode == M_DRAIN) nl = (m_lvl > 0) ? m_lvl - 1 : 0;
        else                   nl = (m_lvl < 31) ? m_lvl + 1 : 31;
      end else begin
        nsub = m_sub + 1;
      end
    end
    nmode = m_mode;
    if (m_mode == M_DRAIN) begin
      if (chg)          nmode = M_CHARGE;
      else if (nl == 0) nmode = M_EMPTY;
    end else if (m_mode == M_CHARGE) begin
      if (!chg) nmode = M_DRAIN;
    end else begin
      if (bus.refill) nmode = M_DRAIN;
      else if (chg)   nmode = M_CHARGE;
    end
    if (nmode != m_mode) nsub = 0;
    m_lc = (nl != m_lvl) ? 1 : 0;
    if (nl <= 5)       m_lw = 1;
    else if (nl >= 10) m_lw = 0;
    m_lvl  = nl;
    m_sub  = nsub;
    m_mode = nmode;
    m_pre  = tick ? 0 : m_pre + 1;
    m_s2   = m_s1;
    m_s1   = bus.charger_in ? 1 : 0;
  endtask

  task automatic check_all();
    check("battery", bus.battery, m_lvl);
    check("level_changed", bus.level_changed, m_lc);
    check("full", bus.full, (m_lvl == 31) ? 1 : 0);
    check("empty", bus.empty, (m_lvl == 0) ? 1 : 0);
`ifdef BATTERY_GAUGE_LOW_WARN_EN
    check("low_warn", bus.low_warn, m_lw);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run_to_level(input int target, input int budget);
    int n;
    n = 0;
    while (m_lvl != target && n < budget) begin
      cycle();
      n++;
    end
    check("reach_level", bus.battery, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.charger_in = 1'b0;
    bus.load_pulse = 1'b0;
    bus.refill     = 1'b0;
    rst_n          = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("reset_battery", bus.battery, 31);
    check("reset_full", bus.full, 1);
    @(negedge clk) rst_n = 1'b1;

    // Passive drain: 31 -> 30 after 8 clocks, 29 after 16, one strobe per step
    strobes = 0;
    repeat (8) begin cycle(); if (bus.level_changed) strobes++; end
    check("first_step", bus.battery, 30);
    check("full_drops", bus.full, 0);
    repeat (8) begin cycle(); if (bus.level_changed) strobes++; end
    check("second_step", bus.battery, 29);
    check("drain_strobes", strobes, 2);

    // Load at level 2 floors at 0 and depletes
    run_to_level(2, 400);
    bus.load_pulse = 1'b1;
    cycle();
    bus.load_pulse = 1'b0;
    check("load_floor", bus.battery, 0);
    check("load_empty", bus.empty, 1);
    check("load_strobe", bus.level_changed, 1);
    strobes = 0;
    repeat (40) begin cycle(); if (bus.level_changed) strobes++; end
    check("depleted_hold", bus.battery, 0);
    check("depleted_strobes", strobes, 0);

    // Charge from empty up to saturation
    bus.charger_in = 1'b1;
    run_to_level(1, 40);
    run_to_level(31, 400);
    strobes = 0;
    repeat (20) begin cycle(); if (bus.level_changed) strobes++; end
    check("charge_sat", bus.battery, 31);
    check("charge_full", bus.full, 1);
    check("sat_strobes", strobes, 0);

    // refill and load together at 12: refill wins, single strobe
    bus.charger_in = 1'b0;
    run_to_level(12, 300);
    bus.refill     = 1'b1;
    bus.load_pulse = 1'b1;
    cycle();
    bus.refill     = 1'b0;
    bus.load_pulse = 1'b0;
    check("refill_wins", bus.battery, 31);
    check("refill_strobe", bus.level_changed, 1);
    cycle();
    check("refill_single_strobe", bus.level_changed, 0);

    // Reset mid-charge at 20
    run_to_level(19, 200);
    bus.charger_in = 1'b1;
    run_to_level(20, 100);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midreset_battery", bus.battery, 31);
    check("midreset_full", bus.full, 1);
    check("midreset_strobe", bus.level_changed, 0);
    model_reset();
    bus.charger_in = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (8) cycle();
    check("prescaler_restart", bus.battery, 30);

    // Low-warning hysteresis path: drain to 5, charge back to 10
    run_to_level(6, 400);
`ifdef BATTERY_GAUGE_LOW_WARN_EN
    check("low_warn_at6", bus.low_warn, 0);
`endif
    run_to_level(5, 50);
`ifdef BATTERY_GAUGE_LOW_WARN_EN
    check("low_warn_at5", bus.low_warn, 1);
`endif
    run_to_level(3, 50);
    bus.charger_in = 1'b1;
    run_to_level(9, 100);
`ifdef BATTERY_GAUGE_LOW_WARN_EN
    check("low_warn_at9", bus.low_warn, 1);
`endif
    run_to_level(10, 50);
`ifdef BATTERY_GAUGE_LOW_WARN_EN
    check("low_warn_at10", bus.low_warn, 0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) bus.charger_in = ~bus.charger_in;
      bus.load_pulse = ($urandom_range(0, 19) == 0);
      bus.refill     = ($urandom_range(0, 149) == 0);
      cycle();
    end
    bus.load_pulse = 1'b0;
    bus.refill     = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
